// File: rtl/dnn_loader_pkg.sv
// Shared constants and types for the serial bank loader.
package dnn_loader_pkg;

  localparam logic [3:0] OP_IDLE = 4'h0;
  localparam logic [3:0] OP_LOAD = 4'h2;

  localparam int unsigned OP_LSB   = 0;
  localparam int unsigned OP_MSB   = 3;
  localparam int unsigned BANK_LSB = 4;
  localparam int unsigned BANK_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/bit_packer.sv
// LSB-first serial-to-parallel shift register with bit counter.
module bit_packer #(
  parameter  int unsigned ELEM_W = 8,
  localparam int unsigned CNT_W  = $clog2(ELEM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clear,
  input  logic              din,
  output logic [ELEM_W-1:0] word,
  output logic [ELEM_W-1:0] word_next,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  // Word as it will look once the current bit lands; full means this shift completes it.
  always_comb begin
    word_next        = word;
    word_next[count] = din;
    full             = (count == CNT_W'(ELEM_W - 1));
  end

  // clear+shift together starts a fresh word with din as bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (clear && shift) begin
      word  <= {{(ELEM_W-1){1'b0}}, din};
      count <= CNT_W'(1);
    end else if (clear) begin
      word  <= '0;
      count <= '0;
    end else if (shift) begin
      if (full) begin
        word  <= '0;
        count <= '0;
      end else begin
        word  <= word_next;
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_bank_loader.sv
// Mode-driven serial-to-parallel loader writing packed words into one of several banks.
module serial_bank_loader
  import dnn_loader_pkg::*;
#(
  parameter  int unsigned ELEM_W    = 8,
  parameter  int unsigned DEPTH     = 256,
  parameter  int unsigned NUM_BANKS = 4,
  localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [31:0]       mode,
  input  logic [31:0]       in_data,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ELEM_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              bad_bank
);

  localparam int unsigned CNT_W = $clog2(ELEM_W);

  state_t state_q, state_d;

  logic [3:0]        op;
  logic [3:0]        mode_bank;
  logic              is_load;
  logic              bank_ok;
  logic              start_ok;
  logic              sess_end;
  logic              addr_last;

  logic [3:0]        bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              pk_shift, pk_clear;
  logic [ELEM_W-1:0] pk_word, pk_word_next;
  logic [CNT_W-1:0]  pk_count;
  logic              pk_full;

  logic              wr_en_d, done_d, busy_d, overflow_d, bad_bank_d;
  logic [BANK_W-1:0] wr_bank_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [ELEM_W-1:0] wr_data_d;

  logic              unused_bits;
  assign unused_bits = ^{mode[31:8], in_data[31:1]};

  assign op        = mode[OP_MSB:OP_LSB];
  assign mode_bank = mode[BANK_MSB:BANK_LSB];
  assign bank_ok   = (32'(mode_bank) < NUM_BANKS);
  assign start_ok  = is_load && bank_ok;
  assign sess_end  = !is_load || (mode_bank != bank_q);
  assign addr_last = (addr_q == ADDR_W'(DEPTH - 1));

  // Op decode: anything other than LOAD behaves as IDLE.
  always_comb begin
    is_load = 1'b0;
    case (op)
      OP_LOAD: is_load = 1'b1;
      OP_IDLE: is_load = 1'b0;
      default: is_load = 1'b0;
    endcase
  end

  bit_packer #(
    .ELEM_W (ELEM_W)
  ) u_packer (
    .clk       (clk),
    .rst       (reset),
    .shift     (pk_shift),
    .clear     (pk_clear),
    .din       (in_data[0]),
    .word      (pk_word),
    .word_next (pk_word_next),
    .count     (pk_count),
    .full      (pk_full)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; FLUSH doubles as a start cycle so a bank switch loses no bit slot.
  always_comb begin
    state_d = state_q;
    if (enable) begin
      unique case (state_q)
        ST_IDLE, ST_FLUSH: state_d = start_ok ? ST_LOAD : ST_IDLE;
        ST_LOAD: begin
          if (sess_end)
            state_d = (pk_count != '0) ? ST_FLUSH : ST_IDLE;
          else if (pk_full && addr_last)
            state_d = ST_HALT;
        end
        ST_HALT: if (sess_end) state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath control; next values of every registered output.
  always_comb begin
    pk_shift   = 1'b0;
    pk_clear   = 1'b0;
    bank_d     = bank_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    wr_bank_d  = wr_bank;
    wr_addr_d  = wr_addr;
    wr_data_d  = wr_data;
    overflow_d = overflow;
    bad_bank_d = bad_bank;
    busy_d     = (state_d != ST_IDLE);
    if (enable) begin
      unique case (state_q)
        ST_IDLE, ST_FLUSH: begin
          if (start_ok) begin
            bank_d   = mode_bank;
            addr_d   = '0;
            pk_clear = 1'b1;
            pk_shift = 1'b1;
          end else if (is_load) begin
            bad_bank_d = 1'b1;
          end
        end
        ST_LOAD: begin
          if (sess_end) begin
            done_d   = 1'b1;
            pk_clear = 1'b1;
            if (pk_count != '0) begin
              wr_en_d   = 1'b1;
              wr_data_d = pk_word;
              wr_addr_d = addr_q;
              wr_bank_d = bank_q[BANK_W-1:0];
            end
          end else begin
            pk_shift = 1'b1;
            if (pk_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = pk_word_next;
              wr_addr_d = addr_q;
              wr_bank_d = bank_q[BANK_W-1:0];
              if (!addr_last) addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        ST_HALT: begin
          if (sess_end) done_d     = 1'b1;
          else          overflow_d = 1'b1;
        end
      endcase
    end
  end

  // Registered outputs, latched bank and word address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_q   <= '0;
      addr_q   <= '0;
      wr_en    <= 1'b0;
      wr_bank  <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      bad_bank <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      wr_en    <= wr_en_d;
      wr_bank  <= wr_bank_d;
      wr_addr  <= wr_addr_d;
      wr_data  <= wr_data_d;
      busy     <= busy_d;
      done     <= done_d;
      overflow <= overflow_d;
      bad_bank <= bad_bank_d;
    end
  end

endmodule

// File: tb/tb_serial_bank_loader.sv
// Scoreboard bench for serial_bank_loader (ELEM_W=8, DEPTH=4, NUM_BANKS=4).
module tb_serial_bank_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] mode;
  logic [31:0] in_data;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        bad_bank;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       wr;
    logic [1:0] bank;
    logic [1:0] addr;
    logic [7:0] data;
    logic       dn;
  } ev_t;

  ev_t expq[$];
  ev_t mon_act;
  ev_t mon_exp;

  always #5 clk = ~clk;

  serial_bank_loader #(
    .ELEM_W    (8),
    .DEPTH     (4),
    .NUM_BANKS (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .mode     (mode),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bad_bank (bad_bank)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t wr_ev(input logic [1:0] b, input logic [1:0] a,
                                input logic [7:0] d, input logic dn);
    ev_t e;
    e.wr = 1'b1; e.bank = b; e.addr = a; e.data = d; e.dn = dn;
    return e;
  endfunction

  function automatic ev_t done_ev();
    ev_t e;
    e = '0;
    e.dn = 1'b1;
    return e;
  endfunction

  // One clock: inputs applied before the edge, outputs observable #1 after it.
  task automatic step(input logic en, input logic [31:0] md, input logic b);
    logic [31:0] r;
    r       = $urandom();
    enable  = en;
    mode    = md;
    in_data = {r[31:1], b};
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of val LSB first; optionally checks the write shows up right after the last bit.
  task automatic send_bits(input string name, input logic [31:0] md, input logic [7:0] val,
                           input int unsigned n, input logic expect_wr);
    for (int unsigned i = 0; i < n; i++) begin
      step(1'b1, md, val[i]);
      check({name, "_busy"}, 32'(busy), 32'd1);
    end
    if (expect_wr) check({name, "_wr_latency"}, 32'(wr_en), 32'd1);
  endtask

  // Monitor: every write or done pulse must match the next expected event.
  always @(negedge clk) begin
    if (wr_en === 1'b1 || done === 1'b1) begin
      mon_act.wr   = wr_en;
      mon_act.bank = wr_en ? wr_bank : 2'b0;
      mon_act.addr = wr_en ? wr_addr : 2'b0;
      mon_act.data = wr_en ? wr_data : 8'h0;
      mon_act.dn   = done;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %h want none at %0t", mon_act, $time);
      end else begin
        mon_exp = expq.pop_front();
        check("scoreboard_event", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; mode = '0; in_data = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_busy",    32'(busy),     32'd0);
    check("rst_wr_en",   32'(wr_en),    32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_ovf",     32'(overflow), 32'd0);
    check("rst_badbank", 32'(bad_bank), 32'd0);
    check("rst_wr_data", 32'(wr_data),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Word pack
    expq.push_back(wr_ev(2'd1, 2'd0, 8'h0D, 1'b0));
    send_bits("pack", 32'h12, 8'h0D, 8, 1'b1);
    expq.push_back(done_ev());
    step(1'b1, 32'h00, 1'b0);
    check("pack_busy_end", 32'(busy), 32'd0);

    // Flush of a 5-bit partial word
    send_bits("flush", 32'h02, 8'h1F, 5, 1'b0);
    expq.push_back(wr_ev(2'd0, 2'd0, 8'h1F, 1'b1));
    step(1'b1, 32'h00, 1'b0);
    check("flush_busy_wr", 32'(busy), 32'd1);
    check("flush_done",    32'(done), 32'd1);
    step(1'b1, 32'h00, 1'b0);
    check("flush_busy_end", 32'(busy), 32'd0);

    // Overflow: 33 ones into a 4-deep bank
    for (int unsigned a = 0; a < 4; a++) expq.push_back(wr_ev(2'd3, 2'(a), 8'hFF, 1'b0));
    for (int unsigned w = 0; w < 4; w++) send_bits("ovf_word", 32'h32, 8'hFF, 8, 1'b1);
    check("ovf_before", 32'(overflow), 32'd0);
    step(1'b1, 32'h32, 1'b1);
    check("ovf_set",   32'(overflow), 32'd1);
    check("ovf_no_wr", 32'(wr_en),    32'd0);
    expq.push_back(done_ev());
    step(1'b1, 32'h00, 1'b0);
    check("ovf_busy_end", 32'(busy), 32'd0);

    // Bank switch with a stall in the middle
    send_bits("sw_a", 32'h12, 8'h09, 4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h12, 1'b1);
      check("stall_wr_en", 32'(wr_en), 32'd0);
      check("stall_busy",  32'(busy),  32'd1);
    end
    expq.push_back(wr_ev(2'd1, 2'd0, 8'h09, 1'b1));
    step(1'b1, 32'h22, 1'b1);
    check("sw_flush_busy", 32'(busy), 32'd1);
    expq.push_back(wr_ev(2'd2, 2'd0, 8'hAA, 1'b0));
    send_bits("sw_b", 32'h22, 8'hAA, 8, 1'b1);
    expq.push_back(done_ev());
    step(1'b1, 32'h00, 1'b0);

    // Bad bank, then a normal load
    step(1'b1, 32'h52, 1'b1);
    check("bad_bank_set", 32'(bad_bank), 32'd1);
    check("bad_busy",     32'(busy),     32'd0);
    step(1'b1, 32'h00, 1'b0);
    expq.push_back(wr_ev(2'd1, 2'd0, 8'hF0, 1'b0));
    send_bits("after_bad", 32'h12, 8'hF0, 8, 1'b1);
    expq.push_back(done_ev());
    step(1'b1, 32'h00, 1'b0);
    check("bad_bank_sticky", 32'(bad_bank), 32'd1);
    check("ovf_sticky",      32'(overflow), 32'd1);

    // Asynchronous reset in the middle of a load
    send_bits("pre_rst", 32'h12, 8'h07, 3, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_busy",    32'(busy),     32'd0);
    check("arst_ovf",     32'(overflow), 32'd0);
    check("arst_badbank", 32'(bad_bank), 32'd0);
    check("arst_wr_en",   32'(wr_en),    32'd0);
    check("arst_wr_data", 32'(wr_data),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    expq.push_back(wr_ev(2'd1, 2'd0, 8'h3C, 1'b0));
    send_bits("post_rst", 32'h12, 8'h3C, 8, 1'b1);
    expq.push_back(done_ev());
    step(1'b1, 32'h00, 1'b0);

    for (int i = 0; i < 4; i++) step(1'b1, 32'h00, 1'b0);
    check("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_bank_loader.md
Name: serial_bank_loader

Overview:
- Mode-driven serial-to-parallel loader for the DNN training datapath.
- Packs a 1-bit-per-cycle `in_data` stream into ELEM_W-bit words.
- Writes the words sequentially into one of NUM_BANKS weight/activation memories, selected by the mode word.
- Successor to the fixed single-bank bit loader: it adds parametrised width, depth and bank count, a zero-padded flush of partial words, and overflow and bad-bank detection.

Parameters:
- ELEM_W, 8, bits per packed element (2..32).
- DEPTH, 256, words per bank; the address counter width is clog2(DEPTH).
- NUM_BANKS, 4, number of target banks (1..16).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  global advance; when low, no state changes except reset.
- mode  in  32  command word: [3:0] op, [7:4] bank; [31:8] ignored.
- in_data  in  32  serial data; only bit [0] is used.
- wr_en  out  1  one-cycle memory write strobe.
- wr_bank  out  clog2(NUM_BANKS)  target bank of the write.
- wr_addr  out  clog2(DEPTH)  word address of the write.
- wr_data  out  ELEM_W  packed word.
- busy  out  1  high while a load session is open.
- done  out  1  one-cycle pulse when a session closes.
- overflow  out  1  sticky; set when bits arrive after DEPTH words have been written.
- bad_bank  out  1  sticky; set when LOAD targets bank >= NUM_BANKS.

Behaviour:
- All outputs are registered. On reset (asynchronous) every output, the shift register, the bit counter, the address counter and the FSM go to 0/IDLE immediately.
- Op codes are constants: OP_IDLE=4'h0, OP_LOAD=4'h2. Any other op is treated as IDLE.
- enable=0 freezes all state. wr_en and done are forced low during that cycle; no bits are lost.
- FSM states: IDLE, LOAD, FLUSH, HALT.
- IDLE:
  - On enable && op==LOAD && bank<NUM_BANKS: latch the bank, clear the bit count and address, go to LOAD. The in_data bit of this same cycle is the first bit (bit 0).
  - On op==LOAD && bank>=NUM_BANKS: set bad_bank and stay in IDLE.
- LOAD:
  - Each enabled cycle shifts in_data[0] into position bitcnt (LSB-first) and increments bitcnt.
  - On the cycle that samples bit ELEM_W-1: the next cycle shows wr_en=1, wr_data=packed word, wr_addr=current address, wr_bank=latched bank. Then address+1 and bitcnt=0.
  - A write latency of 1 cycle after the last bit is sampled is mandatory.
- Session end (op!=LOAD, or bank changed while op==LOAD):
  - If bitcnt>0, go to FLUSH. FLUSH writes the partial word with the upper bits zero-padded, then goes to IDLE with done=1 on that same write cycle.
  - If bitcnt==0, go directly to IDLE and pulse done.
  - The bit present on the terminating cycle is not sampled.
- Bank switch: after FLUSH, if op is still LOAD with a new valid bank, re-enter LOAD on the next enabled cycle at address 0.
- Overflow: after the write to address DEPTH-1, the address does not wrap; the FSM goes to HALT.
  - In HALT, any further LOAD bit sets overflow and no write occurs.
  - HALT exits to IDLE (done pulse) when op!=LOAD or the bank changes.
- busy=1 in LOAD, FLUSH and HALT.
- overflow and bad_bank clear only on reset.
- mode is sampled every enabled cycle; there is no handshake back to the source, and the source must not outrun enable.

Decomposition:
- Package `dnn_loader_pkg`:
  - op code localparams OP_IDLE and OP_LOAD;
  - the mode field slice positions;
  - the FSM state enum typedef.
- Sub-module `bit_packer`: parametrised by ELEM_W; holds the shift register and bit counter, with shift, clear and full outputs. Everything else stays in the top module.

Test Plan (all scenarios use ELEM_W=8, DEPTH=4, NUM_BANKS=4):
- Word pack: mode=0x12, bits 1,0,1,1,0,0,0,0 → exactly one wr_en, 1 cycle after the 8th bit, with wr_bank=1, wr_addr=0, wr_data=0x0D; busy=1 throughout.
- Flush: mode=0x02, bits 1,1,1,1,1, then mode=0x00 → one write of wr_data=0x1F at addr 0 with done=1 in the same cycle; busy falls the next cycle.
- Overflow: mode=0x32 with 33 ones → four writes of 0xFF at addresses 0..3. overflow=1 on the cycle after the 33rd bit; no 5th write. mode=0 → done pulses once with no write.
- Bank switch and stall: mode=0x12 with 4 bits 1,0,0,1, then enable=0 for 3 cycles, then mode=0x22 → flush 0x09 to bank 1 addr 0 with done; the next 8 bits go to bank 2 starting at addr 0.
- Bad bank: mode=0x52 → bad_bank=1, busy stays 0, no writes; a later mode=0x12 loads normally.
- Reset mid-load: assert reset after 3 bits in LOAD → all outputs 0 immediately, without waiting for a clock edge. A new session with mode=0x12 writes to addr 0.
